// File: rtl/rcv_pkg.sv
// Shared types and constants for the receiver-channel arbiter.
// Holds the FSM state encoding, the captured error field and the default
// channel count, plus a helper that sizes channel-index buses.
package rcv_pkg;

  localparam int NUM_CH_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic overrun;
    logic framing;
  } err_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: returns the first asserted request at or above the
// pointer, wrapping from N-1 back to 0.
module rr_pick
  import rcv_pkg::*;
#(
  parameter int N = NUM_CH_DEFAULT,
  localparam int IW = ch_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          valid_o
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    grant_o = '0;
    valid_o = |req_i;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) grant_o = IW'(idx);
    end
  end

endmodule

// File: rtl/rcv_arbiter.sv
// Merges bytes from NUM_CH receivers into one valid/ready stream using
// round-robin selection. One byte is held at a time; the granted receiver
// gets a single-cycle data_read pulse on the grant edge.
// Optional feature: define RCV_ARB_ERR_CNT_EN to build per-channel saturating
// framing-error counters; otherwise err_cnt is tied to zero.
module rcv_arbiter
  import rcv_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  localparam int CH_W = ch_idx_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [NUM_CH-1:0]     ch_data_ready,
  input  logic [NUM_CH*8-1:0]   ch_rx_data,
  input  logic [NUM_CH-1:0]     ch_overrun,
  input  logic [NUM_CH-1:0]     ch_framing,
  output logic [NUM_CH-1:0]     ch_data_read,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic [1:0]            out_err,
  input  logic                  err_cnt_clr,
  output logic [NUM_CH*8-1:0]   err_cnt
);

  state_e              state_q;
  logic [CH_W-1:0]     rr_ptr_q;
  logic                out_valid_q;
  logic [7:0]          out_data_q;
  logic [CH_W-1:0]     out_ch_q;
  err_t                out_err_q;
  logic [NUM_CH-1:0]   ch_data_read_q;

  logic [NUM_CH-1:0]   cand;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_vld;
  logic [CH_W-1:0]     ptr_d;
  logic                grant_fire;
  logic [7:0]          rx_byte [NUM_CH];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rx_slice
      assign rx_byte[gi] = ch_rx_data[gi*8 +: 8];
    end
  endgenerate

  assign cand = ch_data_ready & ch_enable;

  rr_pick #(.N(NUM_CH)) u_rr_pick (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  // Pointer moves just past the granted channel, wrapping at NUM_CH.
  assign ptr_d      = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
  assign grant_fire = (state_q == ST_IDLE) && pick_vld;

  // Arbiter FSM: grant from IDLE, hold the captured byte until accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_ch_q       <= '0;
      out_err_q      <= '0;
      ch_data_read_q <= '0;
    end else begin
      ch_data_read_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            out_data_q        <= rx_byte[pick_idx];
            out_ch_q          <= pick_idx;
            out_err_q.overrun <= ch_overrun[pick_idx];
            out_err_q.framing <= ch_framing[pick_idx];
            out_valid_q       <= 1'b1;
            ch_data_read_q    <= NUM_CH'(1) << pick_idx;
            rr_ptr_q          <= ptr_d;
            state_q           <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_ch       = out_ch_q;
  assign out_err      = out_err_q;
  assign ch_data_read = ch_data_read_q;

`ifdef RCV_ARB_ERR_CNT_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_err_cnt
      logic [7:0] cnt_q;
      // Count grants that carry a framing error; clear has priority.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          cnt_q <= '0;
        end else if (err_cnt_clr) begin
          cnt_q <= '0;
        end else if (grant_fire && (pick_idx == CH_W'(gi)) &&
                     ch_framing[gi] && (cnt_q != 8'hFF)) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      assign err_cnt[gi*8 +: 8] = cnt_q;
    end
  endgenerate
`else
  logic unused_cnt_in;
  assign unused_cnt_in = err_cnt_clr ^ grant_fire;
  assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_rcv_arbiter.sv
// Self-checking bench for rcv_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_rcv_arbiter;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic [N-1:0]   en, rdy, ovr, frm, data_read;
  logic [N*8-1:0] rx;
  logic           out_valid, out_ready, clr;
  logic [7:0]     out_data;
  logic [IW-1:0]  out_ch;
  logic [1:0]     out_err;
  logic [N*8-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic         m_valid;
  logic [7:0]   m_data;
  int           m_ch;
  logic [1:0]   m_err;
  logic [N-1:0] m_pulse;
  int           m_ptr;
  int           m_cnt [N];

  always #5 clk = ~clk;

  rcv_arbiter #(.NUM_CH(N)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .ch_enable     (en),
    .ch_data_ready (rdy),
    .ch_rx_data    (rx),
    .ch_overrun    (ovr),
    .ch_framing    (frm),
    .ch_data_read  (data_read),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .out_err       (out_err),
    .err_cnt_clr   (clr),
    .err_cnt       (err_cnt)
  );

  function automatic int pick(input logic [N-1:0] c, input int p);
    for (int k = 0; k < N; k++)
      if (c[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef RCV_ARB_ERR_CNT_EN
    return m_cnt[c];
`else
    return 0;
`endif
  endfunction

  task automatic model_reset;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_err = '0; m_pulse = '0; m_ptr = 0;
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge,
  // then let receivers that were read drop their data_ready.
  task automatic step;
    logic [N-1:0] cand;
    int g;
    @(posedge clk);
    if (n_rst) begin
      cand    = rdy & en;
      m_pulse = '0;
      if (!m_valid) begin
        g = pick(cand, m_ptr);
        if (g >= 0) begin
          m_valid    = 1'b1;
          m_data     = rx[g*8 +: 8];
          m_ch       = g;
          m_err      = {ovr[g], frm[g]};
          m_pulse[g] = 1'b1;
          m_ptr      = (g + 1) % N;
          if (frm[g] && m_cnt[g] < 255) m_cnt[g]++;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (clr) for (int c = 0; c < N; c++) m_cnt[c] = 0;
    end
    #1;
    for (int c = 0; c < N; c++) if (m_pulse[c]) rdy[c] = 1'b0;
  endtask

  task automatic do_reset;
    n_rst = 1'b0;
    en = '1; rdy = '0; ovr = '0; frm = '0; rx = '0; out_ready = 1'b1; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    tests++;
    if ({out_valid, out_data, out_ch, out_err, data_read} !== '0) begin
      fails++; $display("FAIL reset_outputs: got v=%0b d=%0h ch=%0d e=%0b rd=%b required all 0",
                        out_valid, out_data, out_ch, out_err, data_read);
    end
    tests++;
    if (err_cnt !== '0) begin
      fails++; $display("FAIL reset_err_cnt: got %0h required 0", err_cnt);
    end
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_single;
    do_reset();
    rdy = 4'b0100; rx[2*8 +: 8] = 8'hA5; out_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, out_data, out_ch, out_err, data_read} !== {1'b1, 8'hA5, 2'd2, 2'b00, 4'b0100}) begin
      fails++; $display("FAIL single_grant: got v=%0b d=%0h ch=%0d e=%0b rd=%b required v=1 d=a5 ch=2 e=0 rd=0100",
                        out_valid, out_data, out_ch, out_err, data_read);
    end
    step();
    tests++;
    if (data_read !== 4'b0000 || out_valid !== 1'b0) begin
      fails++; $display("FAIL single_release: got v=%0b rd=%b required v=0 rd=0000", out_valid, data_read);
    end
    $display("[TB] single: ch2 byte a5 transferred");
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int c = 0; c < N; c++) rx[c*8 +: 8] = 8'(8'h10 + c);
    rdy = '1; out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      step();
      tests++;
      if (data_read !== N'(1 << k) || out_ch !== IW'(k) || out_data !== 8'(8'h10 + k)) begin
        fails++; $display("FAIL rr_grant%0d: got rd=%b ch=%0d d=%0h required rd=%b ch=%0d d=%0h",
                          k, data_read, out_ch, out_data, N'(1 << k), k, 8'(8'h10 + k));
      end
      step();
      tests++;
      if (data_read !== '0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL rr_gap%0d: got rd=%b v=%0b required rd=0 v=0", k, data_read, out_valid);
      end
    end
    rdy[0] = 1'b1; rx[7:0] = 8'h77;
    step();
    tests++;
    if (data_read !== 4'b0001 || out_data !== 8'h77) begin
      fails++; $display("FAIL rr_wrap: got rd=%b d=%0h required rd=0001 d=77", data_read, out_data);
    end
    step();
    $display("[TB] round_robin: order 0,1,2,3,0 checked");
  endtask

  task automatic test_backpressure;
    int pulses;
    do_reset();
    rdy = 4'b0010; rx[1*8 +: 8] = 8'h3C; ovr[1] = 1'b1; out_ready = 1'b0;
    step();
    tests++;
    if (data_read !== 4'b0010 || out_err !== 2'b10) begin
      fails++; $display("FAIL bp_grant: got rd=%b e=%0b required rd=0010 e=10", data_read, out_err);
    end
    rdy[3] = 1'b1; rx[3*8 +: 8] = 8'hC3;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (data_read !== '0) pulses++;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== IW'(1)) begin
        fails++; $display("FAIL bp_hold%0d: got v=%0b d=%0h ch=%0d required v=1 d=3c ch=1",
                          i, out_valid, out_data, out_ch);
      end
    end
    tests++;
    if (pulses !== 0) begin
      fails++; $display("FAIL bp_extra_pulse: got %0d pulses required 0", pulses);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || data_read !== '0) begin
      fails++; $display("FAIL bp_accept: got v=%0b rd=%b required v=0 rd=0", out_valid, data_read);
    end
    step();
    tests++;
    if (data_read !== 4'b1000 || out_data !== 8'hC3) begin
      fails++; $display("FAIL bp_next: got rd=%b d=%0h required rd=1000 d=c3", data_read, out_data);
    end
    step();
    $display("[TB] backpressure: hold of 5 cycles checked");
  endtask

  task automatic test_enable_errcnt;
    do_reset();
    en = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy[0] = 1'b1; frm[0] = 1'b1; rdy[1] = 1'b1; rx[7:0] = 8'(i);
      step();
      tests++;
      if (data_read !== 4'b0001 || out_err !== 2'b01) begin
        fails++; $display("FAIL en_grant%0d: got rd=%b e=%0b required rd=0001 e=01", i, data_read, out_err);
      end
      step();
      tests++;
      if (data_read !== '0) begin
        fails++; $display("FAIL en_masked%0d: got rd=%b required 0000", i, data_read);
      end
    end
    tests++;
    if (err_cnt[7:0] !== 8'(exp_cnt(0)) || err_cnt[N*8-1:8] !== '0) begin
      fails++; $display("FAIL err_cnt_count: got %0h required ch0=%0d others 0", err_cnt, exp_cnt(0));
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests++;
    if (err_cnt !== '0) begin
      fails++; $display("FAIL err_cnt_clear: got %0h required 0", err_cnt);
    end
    $display("[TB] enable_errcnt: ch0 count %0d then cleared", err_cnt[7:0]);
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    rdy = 4'b0100; rx[2*8 +: 8] = 8'h5A; out_ready = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL rst_hold_setup: got v=%0b required 1", out_valid);
    end
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_data, out_ch, out_err, data_read} !== '0) begin
      fails++; $display("FAIL rst_async: got v=%0b d=%0h ch=%0d e=%0b rd=%b required all 0",
                        out_valid, out_data, out_ch, out_err, data_read);
    end
    model_reset();
    rdy = '0; out_ready = 1'b1;
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (data_read !== '0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL rst_quiet%0d: got rd=%b v=%0b required 0", i, data_read, out_valid);
      end
    end
    rdy = 4'b1010;
    step();
    tests++;
    if (data_read !== 4'b0010 || out_ch !== IW'(1)) begin
      fails++; $display("FAIL rst_ptr: got rd=%b ch=%0d required rd=0010 ch=1", data_read, out_ch);
    end
    step();
    $display("[TB] reset_mid_hold: held byte discarded");
  endtask

  task automatic test_random;
    int grants;
    do_reset();
    grants = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!rdy[c] && $urandom_range(0, 2) == 0) begin
          rdy[c] = 1'b1;
          rx[c*8 +: 8] = 8'($urandom);
          ovr[c] = 1'($urandom);
          frm[c] = 1'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) en = N'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      step();
      if (m_pulse != '0) grants++;
      tests++;
      if (out_valid !== m_valid || data_read !== m_pulse) begin
        fails++; $display("FAIL rand_ctrl@%0d: got v=%0b rd=%b required v=%0b rd=%b",
                          i, out_valid, data_read, m_valid, m_pulse);
      end
      if (m_valid) begin
        tests++;
        if (out_data !== m_data || out_ch !== IW'(m_ch) || out_err !== m_err) begin
          fails++; $display("FAIL rand_data@%0d: got d=%0h ch=%0d e=%0b required d=%0h ch=%0d e=%0b",
                            i, out_data, out_ch, out_err, m_data, m_ch, m_err);
        end
      end
      for (int c = 0; c < N; c++) begin
        tests++;
        if (err_cnt[c*8 +: 8] !== 8'(exp_cnt(c))) begin
          fails++; $display("FAIL rand_cnt%0d@%0d: got %0d required %0d", c, i, err_cnt[c*8 +: 8], exp_cnt(c));
        end
      end
    end
    clr = 1'b0;
    $display("[TB] random: 600 cycles, %0d grants", grants);
  endtask

  initial begin
    en = '1; rdy = '0; ovr = '0; frm = '0; rx = '0; out_ready = 1'b1; clr = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_errcnt();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
